// File: rtl/mu0_pkg.sv
// Shared definitions for the parametrised MU0 core: opcodes, FSM states and
// the N/Z flag helper.
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        HALT    = 2'd2
    } state_t;

    function automatic logic [1:0] nz_flags(input logic msb, input logic is_zero);
        return {msb, is_zero};
    endfunction

endpackage

// File: rtl/mu0_alu.sv
// Width-generic accumulator datapath: pass, add or subtract memory data.
module mu0_alu
    import mu0_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        func,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = a;
        case (func)
            OP_LDA:  y = b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/mu0_param.sv
// Parametrised MU0 accumulator core: FETCH/EXECUTE/HALT control with a
// ready-handshake memory port and a restart input.
module mu0_param
    import mu0_pkg::*;
#(
    parameter int DATA_W = 16,
    localparam int ADDR_W = DATA_W - 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mem_ready,
    input  logic              go,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] address,
    output logic              memory_read,
    output logic              memory_write,
    output logic              fetch,
    output logic              halted,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        flags
);

    state_t            state;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] alu_y;
    logic [3:0]        func;
    logic [ADDR_W-1:0] operand;
    logic              mem_op;
    logic              sta_exec;
    logic              take_jump;

    assign func     = ir[DATA_W-1:DATA_W-4];
    assign operand  = ir[ADDR_W-1:0];
    assign mem_op   = (func[3:2] == 2'b00);
    assign sta_exec = (state == EXECUTE) && (func == OP_STA);

    assign take_jump = (func == OP_JMP) ||
                       ((func == OP_JGE) && !acc[DATA_W-1]) ||
                       ((func == OP_JNE) && (acc != '0));

    mu0_alu #(.DATA_W(DATA_W)) u_alu (
        .func (func),
        .a    (acc),
        .b    (data_in),
        .y    (alu_y)
    );

    // Enables are gated by rst_n so an access is abandoned the moment reset asserts.
    assign address      = (state == EXECUTE) ? operand : pc;
    assign memory_read  = rst_n && ((state == FETCH) ||
                          ((state == EXECUTE) && mem_op && (func != OP_STA)));
    assign memory_write = rst_n && sta_exec;
    assign data_out     = sta_exec ? acc : '0;
    assign fetch        = (state == FETCH);
    assign halted       = (state == HALT);
    assign flags        = nz_flags(acc[DATA_W-1], acc == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            acc   <= '0;
            ir    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir    <= data_in;
                        pc    <= pc + 1'b1;
                        state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (mem_op) begin
                        if (mem_ready) begin
                            if (func != OP_STA) acc <= alu_y;
                            state <= FETCH;
                        end
                    end else begin
                        // Jumps only load pc here; the increment lives in FETCH.
                        if (take_jump) pc <= operand;
                        state <= (func == OP_STP) ? HALT : FETCH;
                    end
                end
                HALT: begin
                    if (go) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_param.sv
// Directed bench for mu0_param: 16-bit core with a wait-state memory model and
// a 12-bit core starting at 0xFF for wrap checks.
module tb_mu0_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in, data_out, acc;
    logic [11:0] address, pc;
    logic        mem_ready, go, memory_read, memory_write, fetch, halted;
    logic [1:0]  flags;

    logic        rst12_n;
    logic [11:0] data_in12, data_out12, acc12;
    logic [7:0]  address12, pc12;
    logic        mr12, mw12, fetch12, halted12;
    logic [1:0]  flags12;

    logic [15:0] mem16 [0:4095];
    logic [11:0] mem12 [0:255];
    int          wait_n;
    logic        hold_nr;
    int          wcnt;
    int          wr_cnt = 0;
    logic [11:0] wr_addr = '0;
    logic [15:0] wr_data = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mu0_param #(.DATA_W(16), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .mem_ready(mem_ready), .go(go),
        .data_out(data_out), .address(address), .memory_read(memory_read),
        .memory_write(memory_write), .fetch(fetch), .halted(halted),
        .acc(acc), .pc(pc), .flags(flags)
    );

    mu0_param #(.DATA_W(12), .RESET_PC(8'hFF)) dut12 (
        .clk(clk), .rst_n(rst12_n), .data_in(data_in12), .mem_ready(1'b1), .go(1'b0),
        .data_out(data_out12), .address(address12), .memory_read(mr12),
        .memory_write(mw12), .fetch(fetch12), .halted(halted12),
        .acc(acc12), .pc(pc12), .flags(flags12)
    );

    // Memory model: ready rises after wait_n stalled cycles of any access.
    assign data_in   = mem16[address];
    assign data_in12 = mem12[address12];
    assign mem_ready = !hold_nr && (wcnt >= wait_n);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          wcnt <= 0;
        else if ((memory_read || memory_write) && !mem_ready) wcnt <= wcnt + 1;
        else                                                 wcnt <= 0;
    end

    always @(posedge clk) begin
        if (rst_n && memory_write && mem_ready) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= address;
            wr_data <= data_out;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem16[i] = 16'h0000;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step(2);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #7;
        total++;
        if (pc !== 12'h000 || acc !== 16'h0000) begin
            bad++; $display("FAIL reset_regs pc=%h acc=%h want pc=000 acc=0000", pc, acc);
        end
        total++;
        if (fetch !== 1'b1 || halted !== 1'b0) begin
            bad++; $display("FAIL reset_state fetch=%b halted=%b want 1 0", fetch, halted);
        end
        total++;
        if (memory_read !== 1'b0 || memory_write !== 1'b0 || data_out !== 16'h0) begin
            bad++; $display("FAIL reset_enables rd=%b wr=%b dout=%h want 0 0 0000",
                            memory_read, memory_write, data_out);
        end
        total++;
        if (flags !== 2'b01) begin
            bad++; $display("FAIL reset_flags got=%b want=01", flags);
        end
    endtask

    task automatic test_program(input int waits, input int exp_cycles);
        int          halt_cyc;
        int          wr0;
        logic [11:0] p_addr;
        logic [15:0] p_dout;
        logic        p_rd, p_wr, p_rdy;
        hold_reset();
        clear_mem();
        mem16[0] = 16'h0010; mem16[1] = 16'h2011; mem16[2] = 16'h1012; mem16[3] = 16'h7000;
        mem16[16'h10] = 16'd5; mem16[16'h11] = 16'd7;
        wait_n = waits;
        hold_nr = 1'b0;
        go = 1'b0;
        wr0 = wr_cnt;
        release_reset();
        halt_cyc = 0;
        p_rd = memory_read; p_wr = memory_write; p_rdy = mem_ready;
        p_addr = address; p_dout = data_out;
        for (int c = 1; c <= 60 && halt_cyc == 0; c++) begin
            step(1);
            if ((p_rd || p_wr) && !p_rdy) begin
                total++;
                if (address !== p_addr || memory_read !== p_rd ||
                    memory_write !== p_wr || data_out !== p_dout) begin
                    bad++; $display("FAIL stall_stable w=%0d cyc=%0d addr=%h rd=%b wr=%b dout=%h want %h %b %b %h",
                                    waits, c, address, memory_read, memory_write, data_out,
                                    p_addr, p_rd, p_wr, p_dout);
                end
            end
            if (!memory_write && data_out !== 16'h0) begin
                total++; bad++;
                $display("FAIL dout_idle w=%0d cyc=%0d got=%h want=0000", waits, c, data_out);
            end
            if (halted === 1'b1) halt_cyc = c;
            p_rd = memory_read; p_wr = memory_write; p_rdy = mem_ready;
            p_addr = address; p_dout = data_out;
        end
        total++;
        if (halt_cyc != exp_cycles) begin
            bad++; $display("FAIL halt_cycles w=%0d got=%0d want=%0d", waits, halt_cyc, exp_cycles);
        end
        total++;
        if (pc !== 12'h004 || acc !== 16'd12) begin
            bad++; $display("FAIL prog_regs w=%0d pc=%h acc=%h want 004 000c", waits, pc, acc);
        end
        total++;
        if (wr_cnt != wr0 + 1 || wr_addr !== 12'h012 || wr_data !== 16'd12) begin
            bad++; $display("FAIL prog_store w=%0d n=%0d addr=%h data=%h want 1 012 000c",
                            waits, wr_cnt - wr0, wr_addr, wr_data);
        end
        total++;
        if (memory_read !== 1'b0 || memory_write !== 1'b0) begin
            bad++; $display("FAIL halt_enables rd=%b wr=%b want 0 0", memory_read, memory_write);
        end
    endtask

    task automatic test_branch();
        hold_reset();
        clear_mem();
        mem16[12'h000] = 16'h0010;  // LDA 0x10 -> 0x8000
        mem16[12'h001] = 16'h5020;  // JGE, not taken
        mem16[12'h002] = 16'h6020;  // JNE, taken
        mem16[12'h020] = 16'h0011;  // LDA 0x11 -> 0
        mem16[12'h021] = 16'h6030;  // JNE, not taken
        mem16[12'h022] = 16'h7000;
        mem16[12'h010] = 16'h8000;
        mem16[12'h011] = 16'h0000;
        wait_n = 0; hold_nr = 1'b0; go = 1'b0;
        release_reset();
        step(2);
        total++;
        if (acc !== 16'h8000 || flags !== 2'b10) begin
            bad++; $display("FAIL br_lda acc=%h flags=%b want 8000 10", acc, flags);
        end
        step(2);
        total++;
        if (pc !== 12'h002 || fetch !== 1'b1) begin
            bad++; $display("FAIL br_jge_not pc=%h fetch=%b want 002 1", pc, fetch);
        end
        step(2);
        total++;
        if (pc !== 12'h020 || address !== 12'h020) begin
            bad++; $display("FAIL br_jne_taken pc=%h addr=%h want 020 020", pc, address);
        end
        step(2);
        total++;
        if (acc !== 16'h0000 || flags !== 2'b01) begin
            bad++; $display("FAIL br_lda0 acc=%h flags=%b want 0000 01", acc, flags);
        end
        step(2);
        total++;
        if (pc !== 12'h022 || flags !== 2'b01) begin
            bad++; $display("FAIL br_jne_not pc=%h flags=%b want 022 01", pc, flags);
        end
    endtask

    task automatic test_halt_restart();
        hold_reset();
        clear_mem();
        for (int i = 0; i < 5; i++) mem16[i] = 16'h8000;
        mem16[5] = 16'h7000;
        mem16[6] = 16'h0010;
        mem16[7] = 16'h7000;
        mem16[16'h10] = 16'h1234;
        wait_n = 0; hold_nr = 1'b0;
        go = 1'b1;
        release_reset();
        step(11);
        total++;
        if (halted !== 1'b0 || fetch !== 1'b0 || pc !== 12'h006) begin
            bad++; $display("FAIL go_ignored halted=%b fetch=%b pc=%h want 0 0 006", halted, fetch, pc);
        end
        go = 1'b0;
        step(1);
        total++;
        if (halted !== 1'b1 || pc !== 12'h006 || memory_read !== 1'b0) begin
            bad++; $display("FAIL stp_halt halted=%b pc=%h rd=%b want 1 006 0", halted, pc, memory_read);
        end
        step(3);
        total++;
        if (halted !== 1'b1 || pc !== 12'h006) begin
            bad++; $display("FAIL halt_hold halted=%b pc=%h want 1 006", halted, pc);
        end
        go = 1'b1;
        step(1);
        go = 1'b0;
        total++;
        if (fetch !== 1'b1 || address !== 12'h006 || memory_read !== 1'b1) begin
            bad++; $display("FAIL restart fetch=%b addr=%h rd=%b want 1 006 1", fetch, address, memory_read);
        end
        step(2);
        total++;
        if (acc !== 16'h1234) begin
            bad++; $display("FAIL restart_lda acc=%h want 1234", acc);
        end
        step(2);
        total++;
        if (halted !== 1'b1 || pc !== 12'h008) begin
            bad++; $display("FAIL rehalt halted=%b pc=%h want 1 008", halted, pc);
        end
    endtask

    task automatic test_reset_mid_sta();
        int wr0;
        hold_reset();
        clear_mem();
        mem16[0] = 16'h0010;
        mem16[1] = 16'h1012;
        mem16[16'h10] = 16'h00AA;
        wait_n = 0; hold_nr = 1'b0; go = 1'b0;
        release_reset();
        step(3);
        hold_nr = 1'b1;
        wr0 = wr_cnt;
        step(2);
        total++;
        if (memory_write !== 1'b1 || data_out !== 16'h00AA || address !== 12'h012) begin
            bad++; $display("FAIL sta_stall wr=%b dout=%h addr=%h want 1 00aa 012",
                            memory_write, data_out, address);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (memory_write !== 1'b0 || memory_read !== 1'b0 || data_out !== 16'h0) begin
            bad++; $display("FAIL rst_abort wr=%b rd=%b dout=%h want 0 0 0000",
                            memory_write, memory_read, data_out);
        end
        step(2);
        hold_nr = 1'b0;
        release_reset();
        #1;
        total++;
        if (pc !== 12'h000 || acc !== 16'h0000 || wr_cnt != wr0) begin
            bad++; $display("FAIL rst_after pc=%h acc=%h writes=%0d want 000 0000 0",
                            pc, acc, wr_cnt - wr0);
        end
    endtask

    task automatic test_wrap12();
        for (int i = 0; i < 256; i++) mem12[i] = 12'h800;
        mem12[8'hFF] = 12'h010;  // LDA 0x10
        mem12[8'h00] = 12'h211;  // ADD 0x11
        mem12[8'h01] = 12'h700;  // STP
        mem12[8'h10] = 12'hFFF;
        mem12[8'h11] = 12'h001;
        #1;
        total++;
        if (pc12 !== 8'hFF || acc12 !== 12'h000) begin
            bad++; $display("FAIL w12_reset pc=%h acc=%h want ff 000", pc12, acc12);
        end
        @(negedge clk);
        rst12_n = 1'b1;
        step(1);
        total++;
        if (pc12 !== 8'h00) begin
            bad++; $display("FAIL w12_pc_wrap got=%h want=00", pc12);
        end
        step(1);
        total++;
        if (acc12 !== 12'hFFF || flags12 !== 2'b10) begin
            bad++; $display("FAIL w12_lda acc=%h flags=%b want fff 10", acc12, flags12);
        end
        step(2);
        total++;
        if (acc12 !== 12'h000 || flags12 !== 2'b01) begin
            bad++; $display("FAIL w12_add acc=%h flags=%b want 000 01", acc12, flags12);
        end
        step(2);
        total++;
        if (halted12 !== 1'b1 || pc12 !== 8'h02 || data_out12 !== 12'h000) begin
            bad++; $display("FAIL w12_halt halted=%b pc=%h dout=%h want 1 02 000",
                            halted12, pc12, data_out12);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rst12_n = 1'b0;
        go = 1'b0;
        hold_nr = 1'b0;
        wait_n = 0;
        clear_mem();
        test_reset();
        test_program(0, 8);
        test_program(3, 29);
        test_branch();
        test_halt_restart();
        test_reset_mid_sta();
        test_wrap12();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
